// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode: a DEPTH-entry circular
// buffer of {pc, instr} pairs with flush, a discarded-entry counter and a
// jal/jalr link value on the head.
// Optional same-cycle empty-queue bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_instr,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pc8,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                flush_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned FW = 16;

    logic [31:0]    pc_mem_q    [DEPTH];
    logic [31:0]    instr_mem_q [DEPTH];

    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [FW-1:0]  flush_cnt_q, flush_cnt_d;

    logic           empty_c;
    logic           full_c;
    logic           bypass_c;
    logic           push_c;
    logic           pop_c;
    logic           consumed_c;
    logic [CW-1:0]  discard_c;
    logic [FW:0]    fc_sum_c;

    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == CW'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_c = empty_c && in_valid && !flush;
`else
    assign bypass_c = 1'b0;
`endif

    // Handshake status; in_ready depends on registered occupancy only
    assign in_ready   = !full_c;
    assign out_valid  = !empty_c || bypass_c;
    assign count      = count_q;
    assign flush_cnt  = flush_cnt_q;

    // A bypassed instruction taken by decode never touches storage
    assign push_c     = in_valid && !full_c && !flush && !(bypass_c && out_ready);
    assign pop_c      = !empty_c && out_ready && !flush;
    assign consumed_c = out_valid && out_ready;

    // Entries lost to a flush exclude a head that decode took in that cycle
    assign discard_c  = count_q - CW'(consumed_c);
    assign fc_sum_c   = {1'b0, flush_cnt_q} + (FW+1)'(discard_c);

    // Head selection: nop at RESET_PC whenever nothing is valid
    always_comb begin
        out_pc    = RESET_PC;
        out_instr = 32'h0000_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (bypass_c) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end else
`endif
        if (!empty_c) begin
            out_pc    = pc_mem_q[rd_ptr_q];
            out_instr = instr_mem_q[rd_ptr_q];
        end
    end

    // Link value, carry discarded
    assign out_pc8 = out_pc + 32'd8;

    // Next-state for pointers, occupancy and flush statistics
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        flush_cnt_d = flush_cnt_q;
        if (flush) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            flush_cnt_d = fc_sum_c[FW] ? {FW{1'b1}} : fc_sum_c[FW-1:0];
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_c) - CW'(pop_c);
        end
    end

    // Control state registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            flush_cnt_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Entry storage, not reset
    always_ff @(posedge clk) begin
        if (push_c) begin
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_instr;
        end
    end

endmodule
